// File: rtl/fifo_arb_pkg.sv
// ---------------------------------------------------------------------------
// fifo_arb_pkg
//   Shared constants, FSM state encoding and a small helper for the
//   FIFO round-robin pop arbiter.
//   DATA_W   : FIFO word width; the top two bits select the output FIFO.
//   N_IN     : number of input FIFOs (power of two).
//   N_OUT    : number of output FIFOs (4, addressed by the 2 MSBs).
// ---------------------------------------------------------------------------
package fifo_arb_pkg;

   localparam int DATA_W   = 10;
   localparam int N_IN     = 4;
   localparam int N_OUT    = 4;
   localparam int DEST_MSB = DATA_W - 1;
   localparam int DEST_LSB = DATA_W - 2;
   localparam int IDX_W    = $clog2(N_IN);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ACTIVE = 2'b01,
      ST_STALL  = 2'b10
   } arb_state_e;

   // Next round-robin start position after granting idx.
   function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] idx);
      return (int'(idx) == N_IN - 1) ? '0 : idx + 1'b1;
   endfunction

endpackage

// File: rtl/rr_grant.sv
// ---------------------------------------------------------------------------
// rr_grant
//   Combinational round-robin search: first non-empty input FIFO at or
//   after rr_ptr, wrapping around.
//   in_empty : empty flags of the input FIFOs
//   rr_ptr   : search start position (owned by the parent)
//   gnt_oh   : one-hot grant (all zero when nothing found)
//   gnt_idx  : granted index
//   found    : at least one input is non-empty
// ---------------------------------------------------------------------------
module rr_grant
   import fifo_arb_pkg::*;
(
   input  logic [N_IN-1:0]  in_empty,
   input  logic [IDX_W-1:0] rr_ptr,
   output logic [N_IN-1:0]  gnt_oh,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             found
);

   int j;

   always_comb begin
      gnt_oh  = '0;
      gnt_idx = '0;
      found   = 1'b0;
      j       = 0;
      for (int k = 0; k < N_IN; k++) begin
         j = (int'(rr_ptr) + k) % N_IN;
         if (!found && !in_empty[j]) begin
            found      = 1'b1;
            gnt_idx    = IDX_W'(j);
            gnt_oh[j]  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_rr_pop_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_rr_pop_arbiter
//   Pops words round-robin from N_IN input FIFOs and pushes each one to the
//   output FIFO named by its two MSBs. Any output alm_full stalls all pops.
//   clk          : clock, rising edge
//   rst          : asynchronous reset, active high
//   in_empty     : input FIFO empty flags
//   in_data      : input FIFO data_out, FIFO i at [i*DATA_W +: DATA_W]
//   in_rd_enb    : pop strobes (combinational, at most one high)
//   out_alm_full : output FIFO almost-full flags
//   out_wr_enb   : push strobes (registered, at most one high)
//   out_data     : word presented to all output FIFOs (registered)
//   idle         : IDLE state with nothing in flight
// ---------------------------------------------------------------------------
module fifo_rr_pop_arbiter
   import fifo_arb_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_IN-1:0]        in_empty,
   input  logic [N_IN*DATA_W-1:0] in_data,
   output logic [N_IN-1:0]        in_rd_enb,
   input  logic [N_OUT-1:0]       out_alm_full,
   output logic [N_OUT-1:0]       out_wr_enb,
   output logic [DATA_W-1:0]      out_data,
   output logic                   idle
);

   arb_state_e        state_q;
   logic [IDX_W-1:0]  rr_ptr_q;
   logic [IDX_W-1:0]  sel_q;
   logic              vld_q;
   logic [N_IN-1:0]   gnt_oh;
   logic [IDX_W-1:0]  gnt_idx;
   logic              found;
   logic              any_ne;
   logic              any_af;
   logic              pop;
   logic [DATA_W-1:0] word;

   assign any_ne = ~&in_empty;
   assign any_af = |out_alm_full;

   rr_grant u_grant (
      .in_empty (in_empty),
      .rr_ptr   (rr_ptr_q),
      .gnt_oh   (gnt_oh),
      .gnt_idx  (gnt_idx),
      .found    (found)
   );

   // alm_full gates the pop in the same cycle, before the FSM has had a
   // chance to move to STALL; rst gates it while reset is held.
   assign pop       = (state_q == ST_ACTIVE) & ~any_af & found & ~rst;
   assign in_rd_enb = pop ? gnt_oh : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE:   if (any_ne) state_q <= any_af ? ST_STALL : ST_ACTIVE;
            ST_ACTIVE: if (any_af) state_q <= ST_STALL;
                       else if (!any_ne) state_q <= ST_IDLE;
            ST_STALL:  if (!any_af) state_q <= any_ne ? ST_ACTIVE : ST_IDLE;
            default:   state_q <= ST_IDLE;
         endcase
      end
   end

   // Input FIFO data is valid the cycle after the pop, so sel_q picks it then.
   assign word = in_data[sel_q*DATA_W +: DATA_W];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_q   <= '0;
         sel_q      <= '0;
         vld_q      <= 1'b0;
         out_wr_enb <= '0;
         out_data   <= '0;
      end else begin
         vld_q <= pop;
         if (pop) begin
            sel_q    <= gnt_idx;
            rr_ptr_q <= ptr_inc(gnt_idx);
         end
         // In-flight words always complete, regardless of alm_full.
         if (vld_q) begin
            out_data   <= word;
            out_wr_enb <= N_OUT'(1) << word[DEST_MSB:DEST_LSB];
         end else begin
            out_wr_enb <= '0;
         end
      end
   end

   assign idle = (state_q == ST_IDLE) & ~vld_q & ~|out_wr_enb;

endmodule

// File: tb/tb_fifo_rr_pop_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_rr_pop_arbiter
//   Directed bench: behavioural input FIFOs (registered read), pop/push
//   loggers sampled on the falling edge, hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_fifo_rr_pop_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  in_empty;
   logic [39:0] in_data;
   logic [3:0]  in_rd_enb;
   logic [3:0]  out_alm_full;
   logic [3:0]  out_wr_enb;
   logic [9:0]  out_data;
   logic        idle;

   fifo_rr_pop_arbiter dut (
      .clk          (clk),
      .rst          (rst),
      .in_empty     (in_empty),
      .in_data      (in_data),
      .in_rd_enb    (in_rd_enb),
      .out_alm_full (out_alm_full),
      .out_wr_enb   (out_wr_enb),
      .out_data     (out_data),
      .idle         (idle)
   );

   initial forever #5 clk = ~clk;

   // ---------------- input FIFO models ----------------
   logic [9:0] mem [4][256];
   int         rp [4] = '{default: 0};
   int         wp [4] = '{default: 0};
   logic [9:0] dreg [4] = '{default: '0};
   int         cyc = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int i = 0; i < 4; i++) begin
         if (rst) rp[i] <= wp[i];  // flush on reset
         else if (in_rd_enb[i]) begin
            dreg[i] <= mem[i][rp[i]];
            rp[i]   <= rp[i] + 1;
         end
      end
   end

   always_comb begin
      in_empty = '0;
      in_data  = '0;
      for (int i = 0; i < 4; i++) begin
         in_empty[i]          = (rp[i] == wp[i]);
         in_data[i*10 +: 10]  = dreg[i];
      end
   end

   task automatic push_w(input int f, input logic [9:0] w);
      mem[f][wp[f]] = w;
      wp[f]++;
   endtask

   // ---------------- loggers ----------------
   int         pop_idx[$];
   logic [9:0] pop_word[$];
   int         pop_cyc[$];
   logic [3:0] push_oh[$];
   logic [9:0] push_dat[$];
   int         push_cyc[$];

   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (in_rd_enb[i]) begin
            pop_idx.push_back(i);
            pop_word.push_back(mem[i][rp[i]]);
            pop_cyc.push_back(cyc);
         end
      end
      if (|out_wr_enb) begin
         push_oh.push_back(out_wr_enb);
         push_dat.push_back(out_data);
         push_cyc.push_back(cyc);
      end
   end

   task automatic clr_logs();
      pop_idx.delete(); pop_word.delete(); pop_cyc.delete();
      push_oh.delete(); push_dat.delete(); push_cyc.delete();
   endtask

   // ---------------- checking ----------------
   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_idle(input int max);
      int n = 0;
      @(negedge clk);
      while (!(idle && &in_empty) && n < max) begin
         @(negedge clk);
         n++;
      end
      chk("wait_idle_in_budget", 32'(n < max), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [9:0] ew;
      int         i, k;
      rst          = 1'b1;
      out_alm_full = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_rd_enb", 32'(in_rd_enb), 0);
      chk("rst_wr_enb", 32'(out_wr_enb), 0);
      chk("rst_out_data", 32'(out_data), 0);
      chk("rst_idle", 32'(idle), 1);
      @(posedge clk); #1 rst = 1'b0;

      // ---- single source ----
      clr_logs();
      push_w(0, 10'h205);
      push_w(0, 10'h103);
      wait_idle(50);
      chk("ss_npop", 32'(pop_idx.size()), 2);
      chk("ss_pop0_idx", 32'(pop_idx[0]), 0);
      chk("ss_pop1_idx", 32'(pop_idx[1]), 0);
      chk("ss_pop_gap", 32'(pop_cyc[1] - pop_cyc[0]), 1);
      chk("ss_npush", 32'(push_oh.size()), 2);
      chk("ss_push0_oh", 32'(push_oh[0]), 32'h4);
      chk("ss_push0_dat", 32'(push_dat[0]), 32'h205);
      chk("ss_push0_lat", 32'(push_cyc[0] - pop_cyc[0]), 2);
      chk("ss_push1_oh", 32'(push_oh[1]), 32'h2);
      chk("ss_push1_dat", 32'(push_dat[1]), 32'h103);
      chk("ss_push1_lat", 32'(push_cyc[1] - pop_cyc[1]), 2);
      chk("ss_idle", 32'(idle), 1);

      // ---- reset mid-traffic ----
      @(posedge clk); #1;
      push_w(1, 10'h311); push_w(1, 10'h0F2); push_w(1, 10'h1E3); push_w(1, 10'h2D4);
      repeat (3) @(posedge clk);
      #2 chk("mr_busy_before_rst", 32'(|out_wr_enb), 1);
      #1 rst = 1'b1;
      #1;
      chk("mr_rd_enb", 32'(in_rd_enb), 0);
      chk("mr_wr_enb", 32'(out_wr_enb), 0);
      chk("mr_out_data", 32'(out_data), 0);
      chk("mr_idle", 32'(idle), 1);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("mr_flushed_idle", 32'(idle && &in_empty), 1);
      chk("mr_ptr", 32'(dut.rr_ptr_q), 0);

      // ---- round-robin, 3 words per FIFO ----
      @(posedge clk); #1;
      clr_logs();
      for (k = 0; k < 3; k++)
         for (i = 0; i < 4; i++) push_w(i, {2'(i + k), 8'(16 * i + k + 1)});
      wait_idle(100);
      chk("rr_npop", 32'(pop_idx.size()), 12);
      chk("rr_npush", 32'(push_dat.size()), 12);
      for (int n = 0; n < 12; n++) begin
         ew = {2'((n % 4) + (n / 4)), 8'(16 * (n % 4) + (n / 4) + 1)};
         chk($sformatf("rr_pop_idx[%0d]", n), 32'(pop_idx[n]), 32'(n % 4));
         chk($sformatf("rr_pop_cyc[%0d]", n), 32'(pop_cyc[n] - pop_cyc[0]), 32'(n));
         chk($sformatf("rr_dat[%0d]", n), 32'(push_dat[n]), 32'(ew));
         chk($sformatf("rr_oh[%0d]", n), 32'(push_oh[n]), 32'(4'b0001 << ew[9:8]));
      end

      // ---- wrap and skip, starting from rr_ptr=3 ----
      @(posedge clk); #1;
      push_w(2, 10'h0AA);
      wait_idle(50);
      chk("ws_ptr_start", 32'(dut.rr_ptr_q), 3);
      @(posedge clk); #1;
      clr_logs();
      push_w(1, 10'h011); push_w(3, 10'h133);
      push_w(1, 10'h212); push_w(3, 10'h334);
      wait_idle(50);
      chk("ws_npop", 32'(pop_idx.size()), 4);
      chk("ws_pop0", 32'(pop_idx[0]), 3);
      chk("ws_pop1", 32'(pop_idx[1]), 1);
      chk("ws_pop2", 32'(pop_idx[2]), 3);
      chk("ws_pop3", 32'(pop_idx[3]), 1);
      chk("ws_ptr_end", 32'(dut.rr_ptr_q), 2);

      // ---- backpressure with 64 random words ----
      @(posedge clk); #1;
      clr_logs();
      for (int n = 0; n < 64; n++) push_w(int'($urandom_range(0, 3)), 10'($urandom));
      repeat (8) @(posedge clk);
      #1 out_alm_full = 4'b0100;
      for (int n = 0; n < 4; n++) begin
         @(negedge clk);
         chk($sformatf("bp_rd_blocked[%0d]", n), 32'(in_rd_enb), 0);
         if (n > 0) chk($sformatf("bp_state_stall[%0d]", n), 32'(dut.state_q), 32'(2'b10));
         // two words were already popped when the flag rose
         chk($sformatf("bp_inflight_push[%0d]", n), 32'(|out_wr_enb), 32'(n < 2));
         @(posedge clk); #1;
      end
      out_alm_full = '0;
      @(negedge clk);
      chk("bp_drop_cycle_stall", 32'(dut.state_q), 32'(2'b10));
      @(negedge clk);
      chk("bp_resume_active", 32'(dut.state_q), 32'(2'b01));
      chk("bp_resume_pop", 32'(|in_rd_enb), 1);
      wait_idle(300);
      chk("bp_npop", 32'(pop_word.size()), 64);
      chk("bp_npush", 32'(push_dat.size()), 64);
      for (int n = 0; n < 64; n++) begin
         ew = pop_word[n];
         chk($sformatf("bp_dat[%0d]", n), 32'(push_dat[n]), 32'(ew));
         chk($sformatf("bp_oh[%0d]", n), 32'(push_oh[n]), 32'(4'b0001 << ew[9:8]));
      end

      // ---- empty / refill ----
      @(posedge clk); #1;
      clr_logs();
      push_w(2, 10'h3C7);
      @(negedge clk);
      chk("er_empty_fell", 32'(in_empty), 32'b1011);
      @(negedge clk);
      chk("er_first_pop", 32'(in_rd_enb), 32'b0100);
      chk("er_idle_low", 32'(idle), 0);
      wait_idle(50);
      chk("er_push_dat", 32'(push_dat[0]), 32'h3C7);
      chk("er_push_oh", 32'(push_oh[0]), 32'b1000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule
